// File: rtl/fifo_rst_pkg.sv
// Shared definitions for the TMR FIFO reset sequencer and its FIFO-side responder:
// state codes, counter width and the bitwise majority vote.
package fifo_rst_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned MAJ_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_IN_RST    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_CHECK     = 3'd3,
    ST_READY     = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // Callers zero-extend to MAJ_W and truncate the result back to their own width.
  function automatic logic [MAJ_W-1:0] maj3(input logic [MAJ_W-1:0] a,
                                            input logic [MAJ_W-1:0] b,
                                            input logic [MAJ_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_vote_reg.sv
// Triplicated register with asynchronous reset value, majority-voted output
// and a flag raised whenever the three replicas disagree.
module tmr_vote_reg
  import fifo_rst_pkg::*;
#(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         mism
);

  logic [W-1:0] r0_q, r1_q, r2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q <= RST_VAL;
      r1_q <= RST_VAL;
      r2_q <= RST_VAL;
    end else begin
      r0_q <= d;
      r1_q <= d;
      r2_q <= d;
    end
  end

  always_comb begin
    q    = W'(maj3(MAJ_W'(r0_q), MAJ_W'(r1_q), MAJ_W'(r2_q)));
    mism = (r0_q != r1_q) || (r1_q != r2_q);
  end

endmodule

// File: rtl/fifo_rst_resp_tmr.sv
// FIFO-side responder to the TMR reset sequencer: verifies that every FIFO honoured
// the reset, reports READY or ERR, and requests bounded re-sequencing.
module fifo_rst_resp_tmr
  import fifo_rst_pkg::*;
#(
  parameter int unsigned NFIFO     = 4,
  parameter int unsigned MIN_RST   = 3,
  parameter int unsigned TIMEOUT   = 63,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FIFO_RST,
  input  logic             SEQ_DONE,
  input  logic [NFIFO-1:0] FIFO_BUSY,
  input  logic [NFIFO-1:0] FIFO_EMPTY,
  input  logic [NFIFO-1:0] FIFO_FULL,
  output logic             READY,
  output logic             ERR,
  output logic             RESEQ,
  output logic [1:0]       RETRIES,
  output logic             SEU_DET
);

  localparam logic [CNT_W-1:0] MIN_RST_C   = CNT_W'(MIN_RST);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [1:0]       MAX_RETRY_C = 2'(MAX_RETRY);

  state_e             state_v, state_d;
  logic [STATE_W-1:0] state_vq;
  logic [CNT_W-1:0]   cnt_v, cnt_d;
  logic [1:0]         retries_v, retries_d;
  logic [2:0]         out_v, out_d;
  logic               seu_v, seu_d;
  logic               reseq_d;
  logic               state_mism, cnt_mism, retries_mism, out_mism, seu_mism;

  assign state_v = state_e'(state_vq);

  always_comb begin
    state_d = state_v;
    cnt_d   = cnt_v;
    if (FIFO_RST && state_v != ST_IN_RST) begin
      state_d = ST_IN_RST;
      cnt_d   = 8'd1;
    end else begin
      case (state_v)
        ST_IDLE: ;
        ST_IN_RST: begin
          if (FIFO_RST) begin
            if (cnt_v != '1) cnt_d = cnt_v + 8'd1;
          end else if (cnt_v >= MIN_RST_C) begin
            state_d = ST_WAIT_BUSY;
            cnt_d   = '0;
          end else begin
            state_d = ST_FAULT;
          end
        end
        ST_WAIT_BUSY: begin
          if (FIFO_BUSY == '0) begin
            state_d = ST_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_v + 8'd1;
            if (cnt_d >= TIMEOUT_C) state_d = ST_FAULT;
          end
        end
        ST_CHECK: begin
          if (SEQ_DONE) begin
            state_d = ((&FIFO_EMPTY) && !(|FIFO_FULL)) ? ST_READY : ST_FAULT;
          end else begin
            cnt_d = cnt_v + 8'd1;
            if (cnt_d >= TIMEOUT_C) state_d = ST_FAULT;
          end
        end
        ST_READY: ;
        ST_FAULT: ;
        default: state_d = ST_FAULT;
      endcase
    end
  end

  // Outputs decode the next state so they line up with the voted state register.
  always_comb begin
    reseq_d   = (state_d == ST_FAULT) && (state_v != ST_FAULT) && (retries_v < MAX_RETRY_C);
    retries_d = retries_v + {1'b0, reseq_d};
    out_d     = {state_d == ST_READY, state_d == ST_FAULT, reseq_d};
    seu_d     = seu_v | state_mism | cnt_mism | retries_mism | out_mism | seu_mism;
  end

  tmr_vote_reg #(.W(STATE_W), .RST_VAL(ST_IDLE)) u_state (
    .clk(CLK), .rst(RST), .d(state_d), .q(state_vq), .mism(state_mism)
  );

  tmr_vote_reg #(.W(CNT_W), .RST_VAL('0)) u_cnt (
    .clk(CLK), .rst(RST), .d(cnt_d), .q(cnt_v), .mism(cnt_mism)
  );

  tmr_vote_reg #(.W(2), .RST_VAL('0)) u_retries (
    .clk(CLK), .rst(RST), .d(retries_d), .q(retries_v), .mism(retries_mism)
  );

  tmr_vote_reg #(.W(3), .RST_VAL('0)) u_out (
    .clk(CLK), .rst(RST), .d(out_d), .q(out_v), .mism(out_mism)
  );

  tmr_vote_reg #(.W(1), .RST_VAL('0)) u_seu (
    .clk(CLK), .rst(RST), .d(seu_d), .q(seu_v), .mism(seu_mism)
  );

  assign READY   = out_v[2];
  assign ERR     = out_v[1];
  assign RESEQ   = out_v[0];
  assign RETRIES = retries_v;
  assign SEU_DET = seu_v;

endmodule
